// File: rtl/cpumc_arb_if.sv
// CPU memory-controller bus bundle: CPU and DMA master inputs plus the arbitrated bus outputs.
interface cpumc_arb_if #(
  parameter int unsigned STALL_W = 16
);
  logic [15:0]        cpu_a_in;
  logic               cpu_r_nw_in;
  logic [7:0]         cpu_d_in;
  logic               hci_req_in;
  logic [15:0]        hci_a_in;
  logic               hci_r_nw_in;
  logic [7:0]         hci_d_in;
  logic               dmc_req_in;
  logic [15:0]        dmc_a_in;
  logic               sprdma_req_in;
  logic [15:0]        sprdma_a_in;
  logic               sprdma_r_nw_in;
  logic [7:0]         sprdma_d_in;
  logic [2:0]         gnt_out;
  logic               cpu_ready_out;
  logic [15:0]        cpumc_a_out;
  logic               cpumc_r_nw_out;
  logic [7:0]         cpumc_d_out;
  logic [STALL_W-1:0] stall_cnt_out;
  logic               timeout_out;

  modport slave (
    input  cpu_a_in, cpu_r_nw_in, cpu_d_in,
    input  hci_req_in, hci_a_in, hci_r_nw_in, hci_d_in,
    input  dmc_req_in, dmc_a_in,
    input  sprdma_req_in, sprdma_a_in, sprdma_r_nw_in, sprdma_d_in,
    output gnt_out, cpu_ready_out, cpumc_a_out, cpumc_r_nw_out, cpumc_d_out,
    output stall_cnt_out, timeout_out
  );

  modport master (
    output cpu_a_in, cpu_r_nw_in, cpu_d_in,
    output hci_req_in, hci_a_in, hci_r_nw_in, hci_d_in,
    output dmc_req_in, dmc_a_in,
    output sprdma_req_in, sprdma_a_in, sprdma_r_nw_in, sprdma_d_in,
    input  gnt_out, cpu_ready_out, cpumc_a_out, cpumc_r_nw_out, cpumc_d_out,
    input  stall_cnt_out, timeout_out
  );
endinterface

// File: rtl/cpumc_arb.sv
// Registered request/grant arbiter for the cpumc bus: HCI, DMC and sprite DMA versus the CPU,
// with DMA takeover aligned to CPU read cycles and a guaranteed CPU turnaround cycle.
module cpumc_arb #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned STALL_W = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  cpumc_arb_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_RD, ST_OWN, ST_TURN} state_e;
  typedef enum logic [1:0] {M_HCI, M_DMC, M_SPR} mst_e;

  state_e             state_q, state_d;
  mst_e               owner_q, owner_d;
  logic [2:0]         gnt_q, gnt_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   own_cnt_q, own_cnt_d;
  logic               timeout_q, timeout_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               owner_req;
  logic               dma_own;

  function automatic logic [2:0] onehot(mst_e m);
    logic [2:0] g;
    case (m)
      M_HCI:   g = 3'b100;
      M_DMC:   g = 3'b010;
      default: g = 3'b001;
    endcase
    return g;
  endfunction

  // Request level of whichever master is latched as winner/owner.
  always_comb begin
    owner_req = 1'b0;
    case (owner_q)
      M_HCI:   owner_req = bus.hci_req_in;
      M_DMC:   owner_req = bus.dmc_req_in;
      default: owner_req = bus.sprdma_req_in;
    endcase
  end

  // Next-state logic; grant and READY are registered from the next state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = 3'b000;
    ready_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.hci_req_in) begin
          state_d = ST_OWN;
          owner_d = M_HCI;
        end else if (bus.dmc_req_in) begin
          state_d = ST_WAIT_RD;
          owner_d = M_DMC;
        end else if (bus.sprdma_req_in) begin
          state_d = ST_WAIT_RD;
          owner_d = M_SPR;
        end
      end
      ST_WAIT_RD: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
        end else if (bus.cpu_r_nw_in) begin
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!owner_req) begin
          state_d = ST_TURN;
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_OWN) begin
      gnt_d   = onehot(owner_d);
      ready_d = 1'b0;
    end
  end

  assign dma_own = (state_q == ST_OWN) && (owner_q != M_HCI);

  // Owned-cycle watchdog for DMA masters and saturating CPU stall statistics.
  always_comb begin
    own_cnt_d = own_cnt_q;
    timeout_d = timeout_q;
    stall_d   = stall_q;
    if ((state_q != ST_OWN) && (state_d == ST_OWN)) begin
      own_cnt_d = '0;
    end else if (dma_own && (own_cnt_q != CNT_W'(TIMEOUT))) begin
      own_cnt_d = own_cnt_q + CNT_W'(1);
    end
    if (dma_own && (own_cnt_d == CNT_W'(TIMEOUT))) begin
      timeout_d = 1'b1;
    end
    if (!ready_q && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      owner_q   <= M_HCI;
      gnt_q     <= 3'b000;
      ready_q   <= 1'b1;
      own_cnt_q <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      ready_q   <= ready_d;
      own_cnt_q <= own_cnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

  // Bus mux follows the registered state; DMC is forced to read with zero write data.
  always_comb begin
    bus.cpumc_a_out    = bus.cpu_a_in;
    bus.cpumc_r_nw_out = bus.cpu_r_nw_in;
    bus.cpumc_d_out    = bus.cpu_d_in;
    if (state_q == ST_OWN) begin
      case (owner_q)
        M_HCI: begin
          bus.cpumc_a_out    = bus.hci_a_in;
          bus.cpumc_r_nw_out = bus.hci_r_nw_in;
          bus.cpumc_d_out    = bus.hci_d_in;
        end
        M_DMC: begin
          bus.cpumc_a_out    = bus.dmc_a_in;
          bus.cpumc_r_nw_out = 1'b1;
          bus.cpumc_d_out    = 8'h00;
        end
        default: begin
          bus.cpumc_a_out    = bus.sprdma_a_in;
          bus.cpumc_r_nw_out = bus.sprdma_r_nw_in;
          bus.cpumc_d_out    = bus.sprdma_d_in;
        end
      endcase
    end
  end

  assign bus.gnt_out       = gnt_q;
  assign bus.cpu_ready_out = ready_q;
  assign bus.stall_cnt_out = stall_q;
  assign bus.timeout_out   = timeout_q;

endmodule

// File: doc/cpumc_arb.md
# cpumc_arb

Sequential arbiter for the CPU memory-controller bus (cpumc). It replaces the top level's fixed combinational priority mux with a registered request/grant scheme. Three masters share the bus: the host communication interface (HCI), a DMC sample fetcher and sprite DMA. The block stalls the CPU through its READY input, aligns DMA takeover to CPU read cycles, and guarantees the CPU at least one bus cycle between consecutive grants. It sits between the CPU and the cart/wram/ppu/jp slaves and exports stall statistics for the debugger.

## Interface
Parameters:
- TIMEOUT, 1024: owned-cycle count at which a non-HCI grant is flagged as overlong.
- STALL_W, 16: width of the stall counter.

Ports (reset is synchronous, active-high; one clock):
- clk_in  in  1  system clock, 50 MHz
- rst_in  in  1  synchronous active-high reset
- cpu_a_in  in  16  CPU address
- cpu_r_nw_in  in  1  CPU R/!W
- cpu_d_in  in  8  CPU write data
- hci_req_in  in  1  HCI bus request (level)
- hci_a_in  in  16  HCI address
- hci_r_nw_in  in  1  HCI R/!W
- hci_d_in  in  8  HCI write data
- dmc_req_in  in  1  DMC fetch request (level)
- dmc_a_in  in  16  DMC address; DMC is read-only
- sprdma_req_in  in  1  sprite DMA request (level)
- sprdma_a_in  in  16  sprite DMA address
- sprdma_r_nw_in  in  1  sprite DMA R/!W
- sprdma_d_in  in  8  sprite DMA write data
- gnt_out  out  3  one-hot grant {hci, dmc, sprdma}; registered
- cpu_ready_out  out  1  CPU READY; registered
- cpumc_a_out  out  16  muxed bus address
- cpumc_r_nw_out  out  1  muxed R/!W
- cpumc_d_out  out  8  muxed write data
- stall_cnt_out  out  STALL_W  saturating count of cycles with cpu_ready_out=0
- timeout_out  out  1  sticky overlong-grant flag

## Operation
States:
- IDLE: CPU owns the bus.
- WAIT_RD: a DMA winner is latched; waiting for a CPU read cycle.
- OWN: a granted master owns the bus.
- TURN: one-cycle CPU turnaround.

Transitions (evaluated at each clk_in edge):
- IDLE, hci_req_in=1 -> OWN(hci). HCI does not wait for a read cycle.
- IDLE, otherwise dmc_req_in=1 -> WAIT_RD(dmc); otherwise sprdma_req_in=1 -> WAIT_RD(sprdma).
- Priority on simultaneous requests is hci > dmc > sprdma. Requests are sampled only in IDLE.
- WAIT_RD, latched requester's req=0 -> IDLE; nothing is granted.
- WAIT_RD, else cpu_r_nw_in=1 -> OWN(latched). Otherwise remain.
- The WAIT_RD winner is not changed by new requests, including hci.
- OWN, owner's req=0 -> TURN.
- TURN -> IDLE unconditionally. The CPU is guaranteed ≥1 ready cycle between grants.
- There is no preemption in OWN.

Outputs:
- cpu_ready_out is 0 only in OWN.
- gnt_out is one-hot for the owner in OWN and 000 in all other states.
- The bus mux is combinational from the registered state:
  - In OWN, cpumc_* come from the owner; for DMC, cpumc_r_nw_out=1 and cpumc_d_out=0.
  - In all other states, cpumc_* = cpu_*.

Counters:
- Owned-cycle counter: cleared on entry to OWN and increments each OWN cycle with a dmc or sprdma owner.
- When the count reaches TIMEOUT, timeout_out is set. It stays set until reset. The grant is not revoked.
- stall_cnt_out increments every cycle cpu_ready_out=0 and saturates at 2^STALL_W-1.
- stall_cnt_out is cleared only by reset.

## Timing
- Reset values: state IDLE, gnt_out=000, cpu_ready_out=1, stall_cnt_out=0, timeout_out=0, cpumc_*=cpu_*.
- Reset mid-operation (any state) returns to reset values at the next edge. The grant drops immediately at that edge.
- Request-to-grant latency:
  - hci: 1 cycle.
  - DMA: 1 cycle to WAIT_RD, plus cycles until cpu_r_nw_in=1 is sampled, plus 1.
  - Minimum DMA latency is 2 cycles.
- Release-to-ready latency: req low is sampled at edge N, giving TURN at N (ready=1, gnt=000) and IDLE at N+1. A re-request may win at N+1 at the earliest, so grant is reasserted at N+2 at the earliest.
- A requester must hold req high until its grant, and for the full duration of its transfer.
- Slave read data is returned unchanged to the owner; it is not muxed here.

## Test plan
- Reset response: assert rst_in 2 cycles with cpu_a_in=0x8000 -> gnt_out=000, cpu_ready_out=1, cpumc_a_out=0x8000, stall_cnt_out=0.
- Read-cycle alignment: sprdma_req_in=1 with cpu_r_nw_in=0 for 3 cycles, then 1 -> gnt_out=001 one edge after the read is sampled, cpu_ready_out=0, cpumc_a_out=sprdma_a_in=0x0200.
- Priority and turnaround: hci and sprdma request in the same cycle -> gnt_out=100 after 1 cycle. HCI drops its request -> 1 TURN cycle plus 1 IDLE cycle with ready=1, then sprdma proceeds via WAIT_RD.
- DMC read-only: dmc granted with dmc_a_in=0xC000 -> cpumc_r_nw_out=1, cpumc_d_out=0x00, gnt_out=010.
- Timeout and saturation (TIMEOUT=1024): hold sprdma 1100 cycles -> timeout_out rises on the 1024th owned cycle, grant is held, stall_cnt_out=1100. With STALL_W=4 and 20 stalled cycles -> stall_cnt_out=15.
- Reset mid-OWN: pulse rst_in during a sprdma grant -> next edge gnt_out=000, ready=1, timeout_out=0, stall_cnt_out=0.
